// File: rtl/aes_cbc_ictrl.sv
// aes_cbc_ictrl: decrypt-side controller in front of the aes_icipher pipeline.
// Define AES_CBC_EN for CBC chaining. Without it the block runs in ECB mode.
module aes_cbc_ictrl #(
    parameter int OBUF_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:15][7:0] IV_in,
    input  logic             IV_load,
    input  logic [0:15][7:0] Cipher_in,
    input  logic             Cipher_valid,
    output logic             Cipher_ready,
    output logic             Enable_out,
    output logic [0:15][7:0] Data_out,
    input  logic [0:15][7:0] Dec_in,
    input  logic             Dec_valid,
    output logic [0:15][7:0] Plain_out,
    output logic             Plain_valid,
    input  logic             Plain_ready,
    output logic             Busy,
    output logic             Overflow
);

    localparam int          AW       = $clog2(OBUF_DEPTH);
    localparam logic [AW:0] CRED_MAX = (AW+1)'(OBUF_DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    typedef logic [0:15][7:0] block_t;

    logic [AW:0] credits;
    logic        accept;
    logic        plain_pop;
    logic        dec_take;
    block_t      plain_data;
    logic        ob_write;
    logic        ob_empty;
    logic        ob_full;
    logic [AW:0] ob_wr_ptr;
    logic [AW:0] ob_rd_ptr;
    block_t      ob_mem [OBUF_DEPTH];

`ifdef AES_CBC_EN
    block_t      chain_reg;
    block_t      cf_mem [OBUF_DEPTH];
    logic [AW:0] cf_wr_ptr;
    logic [AW:0] cf_rd_ptr;
    logic        cf_empty;

    // IV_load blocks acceptance so the chain register has a single writer per cycle.
    assign Cipher_ready = (credits != '0) && !IV_load;
    assign cf_empty     = (cf_wr_ptr == cf_rd_ptr);
    assign dec_take     = Dec_valid && !cf_empty;
    assign plain_data   = Dec_in ^ cf_mem[cf_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain_reg <= '0;
            cf_wr_ptr <= '0;
            cf_rd_ptr <= '0;
        end else begin
            if (IV_load) begin
                chain_reg <= IV_in;
            end else if (accept) begin
                chain_reg <= Cipher_in;
            end
            if (accept) begin
                cf_wr_ptr <= cf_wr_ptr + ONE;
            end
            if (dec_take) begin
                cf_rd_ptr <= cf_rd_ptr + ONE;
            end
        end
    end

    // Each accepted block queues the chain value it must be XORed with on return.
    always_ff @(posedge clk) begin
        if (accept) begin
            cf_mem[cf_wr_ptr[AW-1:0]] <= chain_reg;
        end
    end
`else
    logic unused_iv;

    assign unused_iv    = ^{IV_in, IV_load};
    assign Cipher_ready = (credits != '0);
    assign dec_take     = Dec_valid;
    assign plain_data   = Dec_in;
`endif

    assign accept      = Cipher_valid && Cipher_ready;
    assign ob_empty    = (ob_wr_ptr == ob_rd_ptr);
    assign ob_full     = (ob_wr_ptr[AW-1:0] == ob_rd_ptr[AW-1:0]) &&
                         (ob_wr_ptr[AW] != ob_rd_ptr[AW]);
    assign plain_pop   = !ob_empty && Plain_ready;
    // A pop frees the head slot at the same edge, so a full buffer can still take a write.
    assign ob_write    = dec_take && (!ob_full || plain_pop);
    assign Plain_valid = !ob_empty;
    assign Plain_out   = ob_empty ? '0 : ob_mem[ob_rd_ptr[AW-1:0]];
    assign Busy        = (credits != CRED_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            Enable_out <= 1'b0;
            Data_out   <= '0;
        end else begin
            Enable_out <= accept;
            if (accept) begin
                Data_out <= Cipher_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credits <= CRED_MAX;
        end else begin
            case ({accept, plain_pop})
                2'b10: credits <= credits - ONE;
                2'b01: begin
                    if (credits != CRED_MAX) begin
                        credits <= credits + ONE;
                    end
                end
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ob_wr_ptr <= '0;
            ob_rd_ptr <= '0;
            Overflow  <= 1'b0;
        end else begin
            if (ob_write) begin
                ob_wr_ptr <= ob_wr_ptr + ONE;
            end
            if (plain_pop) begin
                ob_rd_ptr <= ob_rd_ptr + ONE;
            end
            if (Dec_valid && !ob_write) begin
                Overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ob_write) begin
            ob_mem[ob_wr_ptr[AW-1:0]] <= plain_data;
        end
    end

endmodule

// File: tb/tb_aes_cbc_ictrl.sv
// Bench for aes_cbc_ictrl: stand-in inverse-cipher pipeline, queue scoreboard, directed SP800-38A cases.
`timescale 1ns/1ps
module tb_aes_cbc_ictrl;

    localparam int DEPTH = 16;
    localparam int NR    = 10;
`ifdef AES_CBC_EN
    localparam bit CBC = 1'b1;
`else
    localparam bit CBC = 1'b0;
`endif

    // SP800-38A F.2.2: index 0 is the IV, 1..4 the ciphertext/plaintext blocks.
    localparam logic [127:0] F_C [0:4] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'h7649abac8119b246cee98e9b12e9197d,
        128'h5086cb9b507219ee95db113a917678b2,
        128'h73bed6b8e3c1743b7116e69e22229516,
        128'h3ff1caa1681fac09120eca307586e1a7};
    localparam logic [127:0] F_P [0:4] = '{
        128'h0,
        128'h6bc1bee22e409f96e93d7e117393172a,
        128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef,
        128'hf69f2445df4f9b17ad2b417be66c3710};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] iv_in = '0;
    logic         iv_load = 1'b0;
    logic [127:0] cipher_in = '0;
    logic         cipher_valid = 1'b0;
    logic         cipher_ready;
    logic         enable_out;
    logic [127:0] data_out;
    logic [127:0] dec_in;
    logic         dec_valid;
    logic [127:0] plain_out;
    logic         plain_valid;
    logic         plain_ready = 1'b0;
    logic         busy;
    logic         overflow;
    logic         inj = 1'b0;
    logic [127:0] inj_data = '0;

    int checks = 0;
    int failures = 0;

    aes_cbc_ictrl #(.OBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .IV_in(iv_in), .IV_load(iv_load),
        .Cipher_in(cipher_in), .Cipher_valid(cipher_valid), .Cipher_ready(cipher_ready),
        .Enable_out(enable_out), .Data_out(data_out),
        .Dec_in(dec_in), .Dec_valid(dec_valid),
        .Plain_out(plain_out), .Plain_valid(plain_valid), .Plain_ready(plain_ready),
        .Busy(busy), .Overflow(overflow));

    always #5 clk = ~clk;

    // Stand-in for the AES-128 inverse cipher: exact for the F.2.2 blocks, a fixed bijection otherwise.
    function automatic logic [127:0] fake_dec(input logic [127:0] c);
        for (int i = 1; i <= 4; i++) begin
            if (c == F_C[i]) return F_P[i] ^ F_C[i-1];
        end
        return {c[119:0], c[127:120]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] exp_vec(input int k);
        return CBC ? F_P[k] : (F_P[k] ^ F_C[k-1]);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pipeline model: NR stages, no reset, no backpressure.
    logic [NR-1:0] pv = '0;
    logic [127:0]  pd [NR] = '{default: '0};
    always @(posedge clk) begin
        pv    <= {pv[NR-2:0], enable_out};
        pd[0] <= data_out;
        for (int i = 1; i < NR; i++) pd[i] <= pd[i-1];
    end
    assign dec_valid = pv[NR-1] | inj;
    assign dec_in    = inj ? inj_data : fake_dec(pd[NR-1]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected plaintext plus the cycle it must appear at the buffer head.
    typedef struct {
        logic [127:0] data;
        int           rdy;
    } exp_t;
    exp_t         exp_q[$];
    int           cyc = 0;
    int           credits_m = DEPTH;
    logic [127:0] chain_m = '0;
    bit           en_exp = 1'b0;
    logic [127:0] dout_exp = '0;
    bit           ovf_exp = 1'b0;

    always @(negedge clk) begin
        int landed;
        int inflight;
        bit vld_exp;
        bit rdy_exp;
        bit acc;
        bit pop;
        if (!rst) begin
            exp_q.delete();
            credits_m = DEPTH;
            chain_m   = '0;
            en_exp    = 1'b0;
            dout_exp  = '0;
            ovf_exp   = 1'b0;
        end else begin
            landed = 0;
            inflight = 0;
            foreach (exp_q[i]) begin
                if (exp_q[i].rdy <= cyc) landed++;
                else inflight++;
            end
            vld_exp = (landed > 0);
            rdy_exp = (credits_m != 0) && !(CBC && iv_load);
            check("cipher_ready", cipher_ready, rdy_exp);
            check("busy", busy, credits_m != DEPTH);
            check("enable_out", enable_out, en_exp);
            check("data_out", data_out, dout_exp);
            check("overflow", overflow, ovf_exp);
            check("plain_valid", plain_valid, vld_exp);
            if (vld_exp) check("plain_out", plain_out, exp_q[0].data);
            acc = cipher_valid && rdy_exp;
            pop = vld_exp && plain_ready;
            if (inj && ((landed == DEPTH && !pop) || (CBC && inflight == 0))) ovf_exp = 1'b1;
            if (acc) begin
                exp_q.push_back('{fake_dec(cipher_in) ^ (CBC ? chain_m : 128'h0), cyc + NR + 2});
                chain_m = cipher_in;
                credits_m--;
                dout_exp = cipher_in;
            end
            if (CBC && iv_load) chain_m = iv_in;
            if (pop) begin
                void'(exp_q.pop_front());
                credits_m++;
            end
            en_exp = acc;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_f22_single(input string tag);
        int lat;
        logic [127:0] got;
        plain_ready = 1'b1;
        iv_in = F_C[0];
        iv_load = 1'b1;
        cipher_valid = 1'b0;
        tick();
        iv_load = 1'b0;
        cipher_valid = 1'b1;
        cipher_in = F_C[1];
        tick();
        cipher_valid = 1'b0;
        lat = 0;
        got = '0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(negedge clk);
            if (plain_valid) begin
                lat = i;
                got = plain_out;
            end
        end
        check({tag, "_latency"}, lat, NR + 2);
        check({tag, "_p1"}, got, exp_vec(1));
        tick();
    endtask

    initial begin
        int acc_cnt;
        bit found;

        // Reset values.
        repeat (5) tick();
        check("rst_cipher_ready", cipher_ready, 1);
        check("rst_enable_out", enable_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_plain_valid", plain_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b1;
        tick();

        run_f22_single("f22");

        // Four F.2.2 blocks back-to-back.
        plain_ready = 1'b1;
        iv_in = F_C[0];
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cipher_valid = 1'b1;
            cipher_in = F_C[k];
            tick();
        end
        cipher_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (plain_valid) found = 1'b1;
        end
        check("b2b_found", found, 1);
        for (int k = 1; k <= 4; k++) begin
            check("b2b_valid", plain_valid, 1);
            check("b2b_data", plain_out, exp_vec(k));
            @(negedge clk);
        end
        check("b2b_end", plain_valid, 0);
        tick();

        // Consumer stalled: credits cap acceptance at the buffer depth.
        plain_ready = 1'b0;
        cipher_valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cipher_in = rnd128();
            #1;
            if (cipher_ready) acc_cnt++;
            tick();
        end
        check("stall_accepts", acc_cnt, DEPTH);
        check("stall_ready_low", cipher_ready, 0);
        check("stall_overflow", overflow, 0);
        // Pop while credits are zero: no accept that cycle, one credit afterwards.
        plain_ready = 1'b1;
        #1;
        check("pop_at_zero_ready", cipher_ready, 0);
        tick();
        plain_ready = 1'b0;
        check("pop_credit_ready", cipher_ready, 1);
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cipher_in = rnd128();
            #1;
            if (cipher_ready) acc_cnt++;
            tick();
        end
        check("one_more_accept", acc_cnt, 1);
        check("stall_overflow_end", overflow, 0);
        cipher_valid = 1'b0;
        plain_ready = 1'b1;
        repeat (40) tick();

        // IV_load alongside Cipher_valid, with an older block still in flight.
        cipher_valid = 1'b1;
        cipher_in = rnd128();
        tick();
        iv_in = rnd128();
        iv_load = 1'b1;
        cipher_in = rnd128();
        #1;
        check("ivload_no_accept", cipher_ready, !CBC);
        tick();
        iv_load = 1'b0;
        tick();
        cipher_valid = 1'b0;
        repeat (30) tick();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cipher_valid = ($urandom % 4) != 0;
            cipher_in = rnd128();
            plain_ready = ($urandom % 3) != 0;
            iv_load = ($urandom % 16) == 0;
            iv_in = rnd128();
            tick();
        end
        cipher_valid = 1'b0;
        iv_load = 1'b0;
        plain_ready = 1'b1;
        repeat (40) tick();
        check("drained", exp_q.size(), 0);

        // Fill the buffer, then force a stray Dec_valid: it must be dropped and flagged.
        plain_ready = 1'b0;
        cipher_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cipher_in = rnd128();
            tick();
        end
        cipher_valid = 1'b0;
        repeat (NR + 5) tick();
        inj_data = rnd128();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        check("inject_overflow", overflow, 1);

        // Reset mid-stream.
        for (int i = 0; i < 8; i++) begin
            cipher_valid = $urandom % 2;
            plain_ready = $urandom % 2;
            cipher_in = rnd128();
            tick();
        end
        rst = 1'b0;
        cipher_valid = 1'b1;
        plain_ready = 1'b1;
        repeat (20) tick();
        check("mid_rst_cipher_ready", cipher_ready, 1);
        check("mid_rst_enable_out", enable_out, 0);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_plain_valid", plain_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overflow", overflow, 0);
        rst = 1'b1;
        cipher_valid = 1'b0;
        repeat (NR + 5) tick();
        check("post_rst_overflow", overflow, 0);
        run_f22_single("rst_f22");
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
